div_ctrl: RTL

- Sequencer that sits directly upstream of the `div` core in the MIX arithmetic unit and executes the MIX DIV instruction.
- Accepts sign-magnitude operands: rA:rX as dividend, V as divisor.
- Performs the overflow and divide-by-zero check, launches the unsigned `div` core, waits its fixed latency, then applies MIX sign rules.
- Presents quotient (new rA) and remainder (new rX) with a done/overflow handshake.

---
 rtl/div_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: MIX DIV instruction sequencer sitting in front of the unsigned
// `div` core. It latches the sign-magnitude operands and rejects overflow or
// divide-by-zero before the core is launched. Otherwise it launches the core
// and waits its fixed latency, then applies the MIX sign rules to the
// quotient (new rA) and the remainder (new rX).
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             single-cycle request, only honoured in IDLE
//   ra_sign, ra, rx   dividend {rA:rX}; rA sign only, rX sign is ignored
//   v_sign, v         divisor
//   core_start        one-cycle launch pulse to the div core
//   core_dividend     {ra,rx} latched at start
//   core_divisor      v latched at start
//   core_quotient     core result, sampled only at the capture edge
//   core_remainder    core result, sampled only at the capture edge
//   busy              high in every state except IDLE
//   done              one-cycle completion pulse
//   overflow          MIX overflow toggle request, valid with done
//   qa_sign, qa       new rA (quotient)
//   rx_sign_out, rx_out  new rX (remainder)
//   state_dbg         current FSM state (IDLE=0, CHECK=1, RUN=2, DONE=3)
//
// Handshake: start is a request with no ready; it is accepted on the first
// rising edge where start=1 while busy=0 and is ignored otherwise. Completion
// is a single-cycle done pulse with no back-pressure; results hold afterwards
// until the next successful capture.
module div_ctrl #(
  parameter int unsigned LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ra_sign,
  input  logic [29:0] ra,
  input  logic [29:0] rx,
  input  logic        v_sign,
  input  logic [29:0] v,
  output logic        core_start,
  output logic [59:0] core_dividend,
  output logic [29:0] core_divisor,
  input  logic [29:0] core_quotient,
  input  logic [29:0] core_remainder,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        qa_sign,
  output logic [29:0] qa,
  output logic        rx_sign_out,
  output logic [29:0] rx_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] LAT8 = 8'(LATENCY);

  state_t     state;
  logic [7:0] cnt;
  logic       ra_sign_q;
  logic       v_sign_q;

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= 8'd0;
      ra_sign_q     <= 1'b0;
      v_sign_q      <= 1'b0;
      core_start    <= 1'b0;
      core_dividend <= 60'd0;
      core_divisor  <= 30'd0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      qa_sign       <= 1'b0;
      qa            <= 30'd0;
      rx_sign_out   <= 1'b0;
      rx_out        <= 30'd0;
    end else begin
      // Pulses default low; each state raises them for exactly one cycle.
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            core_dividend <= {ra, rx};
            core_divisor  <= v;
            ra_sign_q     <= ra_sign;
            v_sign_q      <= v_sign;
            busy          <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          // The quotient fits in 30 bits only if rA < V; this also covers V=0.
          if ((core_divisor == 30'd0) || (core_dividend[59:30] >= core_divisor)) begin
            done     <= 1'b1;
            overflow <= 1'b1;
            state    <= DONE;
          end else begin
            core_start <= 1'b1;
            cnt        <= LAT8;
            state      <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt - 8'd1;
          // cnt==1 marks edge E1+LATENCY, when the core results are valid.
          if (cnt == 8'd1) begin
            qa          <= core_quotient;
            rx_out      <= core_remainder;
            qa_sign     <= ra_sign_q ^ v_sign_q;
            rx_sign_out <= ra_sign_q;
            overflow    <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
